// File: rtl/clk_phase_ctrl.sv
// clk_phase_ctrl: sequencing stage wrapped around the shared counter.
// It clears and enables the counter, compares the returned count against
// latched high/low phase lengths, and generates a registered clock with
// one-cycle rise/fall strobes and a wrapping completed-period tally.
//
// Ports:
//   sys_dom_i      clock domain bundle (clk, clk_en tick qualifier, sync_rst)
//   enable_i       run request, sampled in IDLE and at period boundaries
//   high_len_i     high-phase target in count units
//   low_len_i      low-phase target in count units
//   step_i         counter growth per tick (0 is treated as 1)
//   count_i        count returned by the counter
//   counter_en_o   counter enable
//   init_en_o      counter init (unused, tied 0)
//   clear_en_o     counter clear
//   seed_o         counter seed (constant 0)
//   growth_rate_o  latched step driven to the counter
//   clk_o          generated clock (registered)
//   rise_o/fall_o  one-clk-cycle strobes on clk_o edges
//   busy_o         state is not IDLE
//   period_cnt_o   completed full periods, wraps

package common_p;
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;
endpackage

module clk_phase_ctrl #(
    parameter int BIT_WIDTH        = 8,
    parameter int PERIOD_CNT_WIDTH = 16
) (
    input  common_p::clk_dom_s           sys_dom_i,
    input  logic                         enable_i,
    input  logic [BIT_WIDTH-1:0]         high_len_i,
    input  logic [BIT_WIDTH-1:0]         low_len_i,
    input  logic [BIT_WIDTH-1:0]         step_i,
    input  logic [BIT_WIDTH-1:0]         count_i,
    output logic                         counter_en_o,
    output logic                         init_en_o,
    output logic                         clear_en_o,
    output logic [BIT_WIDTH-1:0]         seed_o,
    output logic [BIT_WIDTH-1:0]         growth_rate_o,
    output logic                         clk_o,
    output logic                         rise_o,
    output logic                         fall_o,
    output logic                         busy_o,
    output logic [PERIOD_CNT_WIDTH-1:0]  period_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic clk;
    logic tick;
    logic rst;

    assign clk  = sys_dom_i.clk;
    assign tick = sys_dom_i.clk_en;
    assign rst  = sys_dom_i.sync_rst;

    state_t                        state;
    state_t                        next_state;
    logic [BIT_WIDTH-1:0]          high_q;
    logic [BIT_WIDTH-1:0]          low_q;
    logic [BIT_WIDTH-1:0]          step_q;
    logic [BIT_WIDTH-1:0]          step_eff;
    logic [BIT_WIDTH-1:0]          target;
    logic [PERIOD_CNT_WIDTH-1:0]   period_q;
    logic                          clk_q;
    logic                          rise_q;
    logic                          fall_q;
    logic                          term;
    logic                          latch;
    logic                          rise_ev;
    logic                          fall_ev;
    logic                          period_ev;

    // The sum is formed one bit wider so count + step never wraps below
    // the target; a target of 0 terminates at count 0 (one-tick phase).
    function automatic logic phase_done(input logic [BIT_WIDTH-1:0] count,
                                        input logic [BIT_WIDTH-1:0] step,
                                        input logic [BIT_WIDTH-1:0] tgt);
        return ({1'b0, count} + {1'b0, step}) >= {1'b0, tgt};
    endfunction

    assign step_eff = (step_i == '0) ? BIT_WIDTH'(1) : step_i;
    assign target   = (state == LOW) ? low_q : high_q;
    assign term     = phase_done(count_i, step_q, target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (tick) begin
            state <= next_state;
        end
    end

    // Counter controls are combinational so the clear lands on the same
    // tick that ends a phase, giving count 0 in the first cycle of the next.
    always_comb begin
        next_state   = state;
        counter_en_o = 1'b0;
        clear_en_o   = 1'b0;
        latch        = 1'b0;
        rise_ev      = 1'b0;
        fall_ev      = 1'b0;
        period_ev    = 1'b0;
        case (state)
            IDLE: begin
                clear_en_o = enable_i;
                if (enable_i) begin
                    latch      = 1'b1;
                    rise_ev    = 1'b1;
                    next_state = HIGH;
                end
            end
            HIGH: begin
                counter_en_o = 1'b1;
                if (term) begin
                    clear_en_o = 1'b1;
                    fall_ev    = 1'b1;
                    next_state = LOW;
                end
            end
            LOW: begin
                counter_en_o = 1'b1;
                if (term) begin
                    clear_en_o = 1'b1;
                    period_ev  = 1'b1;
                    if (enable_i) begin
                        latch      = 1'b1;
                        rise_ev    = 1'b1;
                        next_state = HIGH;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_q <= '0;
            low_q  <= '0;
            step_q <= BIT_WIDTH'(1);
        end else if (tick && latch) begin
            high_q <= high_len_i;
            low_q  <= low_len_i;
            step_q <= step_eff;
        end
    end

    // Strobes are cleared on every clk edge, independent of clk_en, so they
    // stay exactly one clk cycle wide even when ticks are sparse.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            period_q <= '0;
        end else begin
            rise_q <= tick && rise_ev;
            fall_q <= tick && fall_ev;
            if (tick) begin
                clk_q <= (next_state == HIGH);
                if (period_ev) begin
                    period_q <= period_q + PERIOD_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign init_en_o     = 1'b0;
    assign seed_o        = '0;
    assign growth_rate_o = step_q;
    assign clk_o         = clk_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign busy_o        = (state != IDLE);
    assign period_cnt_o  = period_q;

endmodule

// File: tb/tb_clk_phase_ctrl.sv
// Testbench for clk_phase_ctrl with a behavioural model of the paired counter.
// A tick-level reference model (phase lengths from ceil(target/step)) pushes
// expected outputs per clk edge into a queue; a monitor pops and compares.
module tb_clk_phase_ctrl;

    logic        clk = 1'b0;
    logic        ce  = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  hlen = '0;
    logic [7:0]  llen = '0;
    logic [7:0]  stp  = '0;
    logic [7:0]  cnt;
    logic        counter_en, init_en, clear_en;
    logic [7:0]  seed, growth_rate;
    logic        clk_o, rise_o, fall_o, busy_o;
    logic [15:0] period_cnt;
    common_p::clk_dom_s dom;

    assign dom = {clk, ce, rst};

    always #5 clk = ~clk;

    clk_phase_ctrl #(.BIT_WIDTH(8), .PERIOD_CNT_WIDTH(16)) dut (
        .sys_dom_i    (dom),
        .enable_i     (en),
        .high_len_i   (hlen),
        .low_len_i    (llen),
        .step_i       (stp),
        .count_i      (cnt),
        .counter_en_o (counter_en),
        .init_en_o    (init_en),
        .clear_en_o   (clear_en),
        .seed_o       (seed),
        .growth_rate_o(growth_rate),
        .clk_o        (clk_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .busy_o       (busy_o),
        .period_cnt_o (period_cnt)
    );

    // Paired counter: clear has priority over growth, both qualified by clk_en.
    always @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (ce) begin
            if (clear_en) cnt <= '0;
            else if (counter_en) cnt <= cnt + growth_rate;
        end
    end

    typedef struct {
        logic        clk, rise, fall, busy, cen;
        logic [15:0] per;
        logic [7:0]  gr, cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model state (0 idle, 1 high, 2 low)
    int          m_st = 0, m_left = 0, m_len = 1, m_nh = 1, m_nl = 1;
    logic [7:0]  m_s = 8'd1;
    logic        m_clk = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    logic [15:0] m_per = '0;

    function automatic int phase_ticks(input logic [7:0] t, input logic [7:0] s);
        int n;
        n = (int'(t) + int'(s) - 1) / int'(s);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic model_latch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
        m_s    = (s == 8'd0) ? 8'd1 : s;
        m_nh   = phase_ticks(h, m_s);
        m_nl   = phase_ticks(l, m_s);
        m_st   = 1;
        m_len  = m_nh;
        m_left = m_nh;
        m_clk  = 1'b1;
        m_rise = 1'b1;
    endtask

    task automatic step(input logic r, input logic c, input logic en_v,
                        input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
        exp_t x;
        rst = r; ce = c; en = en_v; hlen = h; llen = l; stp = s;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            m_st = 0; m_clk = 1'b0; m_per = '0; m_s = 8'd1; m_left = 0; m_len = 1;
        end else if (c) begin
            case (m_st)
                0: if (en_v) model_latch(h, l, s);
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_st = 2; m_len = m_nl; m_left = m_nl; m_clk = 1'b0; m_fall = 1'b1;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_per++;
                        if (en_v) model_latch(h, l, s);
                        else begin m_st = 0; m_clk = 1'b0; end
                    end
                end
            endcase
        end
        x.clk  = m_clk;
        x.rise = m_rise;
        x.fall = m_fall;
        x.busy = (m_st != 0);
        x.cen  = (m_st != 0);
        x.per  = m_per;
        x.gr   = m_s;
        x.cnt  = (m_st == 0) ? 8'd0 : 8'((m_len - m_left) * int'(m_s));
        sbq.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: one expected entry per clk edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if ({clk_o, rise_o, fall_o, busy_o, counter_en, period_cnt, growth_rate, cnt} !==
                {e.clk, e.rise, e.fall, e.busy, e.cen, e.per, e.gr, e.cnt}) begin
                miscompares++;
                $display("FAIL scoreboard cycle %0d: got clk=%b rise=%b fall=%b busy=%b cen=%b per=%0d gr=%0d cnt=%0d, expected clk=%b rise=%b fall=%b busy=%b cen=%b per=%0d gr=%0d cnt=%0d",
                         cyc, clk_o, rise_o, fall_o, busy_o, counter_en, period_cnt, growth_rate, cnt,
                         e.clk, e.rise, e.fall, e.busy, e.cen, e.per, e.gr, e.cnt);
            end
        end
    end

    task automatic test_reset();
        step(1, 1, 0, 8'd0, 8'd0, 8'd0);
        step(1, 1, 0, 8'd0, 8'd0, 8'd0);
        vectors++;
        if ({clk_o, rise_o, fall_o, busy_o, period_cnt} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got clk=%b rise=%b fall=%b busy=%b per=%0d, expected all 0",
                     clk_o, rise_o, fall_o, busy_o, period_cnt);
        end
        vectors++;
        if (growth_rate !== 8'd1) begin
            miscompares++;
            $display("FAIL reset_step: got %0d, expected 1", growth_rate);
        end
        vectors++;
        if ({counter_en, init_en, seed} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got cen=%b init=%b seed=%0d, expected 0/0/0", counter_en, init_en, seed);
        end
    endtask

    task automatic test_basic();
        step(1, 1, 0, 8'd4, 8'd4, 8'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 8'd4, 8'd4, 8'd1);
            vectors++;
            if (cnt !== 8'(i) || clk_o !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_high_count[%0d]: got cnt=%0d clk=%b, expected cnt=%0d clk=1", i, cnt, clk_o, i);
            end
        end
        step(0, 1, 1, 8'd4, 8'd4, 8'd1);
        vectors++;
        if (clk_o !== 1'b0 || fall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_fall: got clk=%b fall=%b, expected 0/1", clk_o, fall_o);
        end
        // Three 8-tick periods complete at the 25th edge counting the enabling one.
        for (int i = 5; i < 25; i++) step(0, 1, 1, 8'd4, 8'd4, 8'd1);
        vectors++;
        if (period_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL basic_periods: got %0d, expected 3", period_cnt);
        end
    endtask

    task automatic test_step3();
        logic [7:0] exp_cnt [3];
        exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd3; exp_cnt[2] = 8'd6;
        step(1, 1, 0, 8'd7, 8'd2, 8'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 8'd7, 8'd2, 8'd3);
            vectors++;
            if (cnt !== exp_cnt[i] || growth_rate !== 8'd3) begin
                miscompares++;
                $display("FAIL step3_high[%0d]: got cnt=%0d gr=%0d, expected cnt=%0d gr=3", i, cnt, growth_rate, exp_cnt[i]);
            end
        end
        step(0, 1, 1, 8'd7, 8'd2, 8'd3);
        vectors++;
        if (clk_o !== 1'b0 || fall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL step3_fall: got clk=%b fall=%b, expected 0/1", clk_o, fall_o);
        end
        step(0, 1, 1, 8'd7, 8'd2, 8'd3);
        vectors++;
        if (clk_o !== 1'b1 || rise_o !== 1'b1) begin
            miscompares++;
            $display("FAIL step3_low_one_tick: got clk=%b rise=%b, expected 1/1", clk_o, rise_o);
        end
    endtask

    task automatic test_zero();
        step(1, 1, 0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 8'd0, 8'd0, 8'd0);
            vectors++;
            if (clk_o !== ((i % 2) == 0) || growth_rate !== 8'd1) begin
                miscompares++;
                $display("FAIL zero_toggle[%0d]: got clk=%b gr=%0d, expected clk=%b gr=1", i, clk_o, growth_rate, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_clk_en();
        int high_cycles = 0;
        int rise_cycles = 0;
        step(1, 1, 0, 8'd2, 8'd2, 8'd1);
        for (int i = 0; i < 24; i++) begin
            step(0, (i % 3) == 0, 1, 8'd2, 8'd2, 8'd1);
            if (clk_o === 1'b1) high_cycles++;
            if (rise_o === 1'b1) rise_cycles++;
        end
        vectors++;
        if (high_cycles != 12) begin
            miscompares++;
            $display("FAIL clk_en_high_cycles: got %0d, expected 12", high_cycles);
        end
        vectors++;
        if (rise_cycles != 2) begin
            miscompares++;
            $display("FAIL clk_en_rise_width: got %0d strobe cycles, expected 2", rise_cycles);
        end
    endtask

    task automatic test_enable_drop();
        step(1, 1, 0, 8'd5, 8'd5, 8'd1);
        step(0, 1, 1, 8'd5, 8'd5, 8'd1);                        // E1 rise
        step(0, 1, 1, 8'd5, 8'd5, 8'd1);                        // E2
        for (int i = 3; i <= 5; i++) step(0, 1, 1, 8'd2, 8'd5, 8'd1);
        vectors++;
        if (clk_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_midperiod_h: got clk=%b after 5 high edges, expected 1", clk_o);
        end
        for (int i = 6; i <= 11; i++) step(0, 1, 1, 8'd2, 8'd5, 8'd1);
        vectors++;
        if (clk_o !== 1'b1 || rise_o !== 1'b1 || period_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL drop_second_rise: got clk=%b rise=%b per=%0d, expected 1/1/1", clk_o, rise_o, period_cnt);
        end
        step(0, 1, 0, 8'd2, 8'd5, 8'd1);                        // E12, enable dropped mid-HIGH
        step(0, 1, 0, 8'd2, 8'd5, 8'd1);                        // E13
        vectors++;
        if (clk_o !== 1'b0 || fall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_new_high_len: got clk=%b fall=%b, expected 0/1", clk_o, fall_o);
        end
        for (int i = 14; i <= 18; i++) step(0, 1, 0, 8'd2, 8'd5, 8'd1);
        vectors++;
        if (busy_o !== 1'b0 || clk_o !== 1'b0 || period_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL drop_idle: got busy=%b clk=%b per=%0d, expected 0/0/2", busy_o, clk_o, period_cnt);
        end
        step(0, 1, 0, 8'd2, 8'd5, 8'd1);
        step(0, 1, 0, 8'd2, 8'd5, 8'd1);
    endtask

    task automatic test_reset_mid_low();
        bit found = 0;
        step(1, 1, 0, 8'd3, 8'd5, 8'd1);
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1, 1, 8'd3, 8'd5, 8'd1);
            if (busy_o === 1'b1 && clk_o === 1'b0 && cnt === 8'd2) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_low_reach: got no LOW cycle at count 2 within 40 cycles, expected one");
        end
        step(1, 1, 1, 8'd3, 8'd5, 8'd1);
        vectors++;
        if ({busy_o, clk_o, rise_o, fall_o, counter_en, period_cnt} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_low_abort: got busy=%b clk=%b rise=%b fall=%b cen=%b per=%0d, expected all 0",
                     busy_o, clk_o, rise_o, fall_o, counter_en, period_cnt);
        end
        step(0, 1, 0, 8'd3, 8'd5, 8'd1);
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_step3();
        test_zero();
        test_clk_en();
        test_enable_drop();
        test_reset_mid_low();
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
